// File: rtl/jtag_scan_sequencer_if.sv
// Command/response bundle between a scan client and jtag_scan_sequencer.
interface jtag_scan_sequencer_if #(
    parameter int MAXLEN = 32,
    parameter int CNTW   = $clog2(MAXLEN + 1)
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [CNTW-1:0]   cmd_len;
    logic [MAXLEN-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_err;
    logic [MAXLEN-1:0] rsp_data;

    modport master (output cmd_valid, cmd_op, cmd_len, cmd_data,
                    input  cmd_ready, rsp_valid, rsp_err, rsp_data);
    modport slave  (input  cmd_valid, cmd_op, cmd_len, cmd_data,
                    output cmd_ready, rsp_valid, rsp_err, rsp_data);
endinterface

// File: rtl/jtag_scan_sequencer.sv
// JTAG master: expands reset/IR/DR/idle commands into registered TMS/TDI
// streams, captures TDO and mirrors the target TAP state cycle by cycle.
module jtag_scan_sequencer #(
    parameter int MAXLEN = 32,
    parameter int CNTW   = $clog2(MAXLEN + 1)
) (
    input  logic                 tck,
    input  logic                 trst,
    jtag_scan_sequencer_if.slave bus,
    output logic                 tms,
    output logic                 tdi,
    input  logic                 tdo,
    output logic                 busy,
    output logic [3:0]           tap_state
);
    localparam logic [1:0]      OP_RESET = 2'd0;
    localparam logic [1:0]      OP_IR    = 2'd1;
    localparam logic [1:0]      OP_IDLE  = 2'd3;
    localparam logic [CNTW-1:0] MAXL     = CNTW'(MAXLEN);
    localparam logic [CNTW-1:0] ONE      = CNTW'(1);
    localparam logic [CNTW-1:0] RST_LAST = CNTW'(5);

    typedef enum logic [3:0] {
        RST_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, IDLE_CNT, ERR
    } state_t;

    state_t            state, state_n;
    logic [CNTW-1:0]   cnt, cnt_n, len_q;
    logic              cap_ph, cap_ph_n, ir_q, ir_n, rst_cmd, rst_cmd_n;
    logic              done_n, err_n, accept, shift_en, load_rsp, tms_n, tdi_n;
    logic              rsp_valid_q, rsp_err_q;
    logic [MAXLEN-1:0] data_sh, cap, rsp_data_q;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        case (s)
            4'hF: tap_next = m ? 4'hF : 4'hC;
            4'hC: tap_next = m ? 4'h7 : 4'hC;
            4'h7: tap_next = m ? 4'h4 : 4'h6;
            4'h6: tap_next = m ? 4'h1 : 4'h2;
            4'h2: tap_next = m ? 4'h1 : 4'h2;
            4'h1: tap_next = m ? 4'h5 : 4'h3;
            4'h3: tap_next = m ? 4'h0 : 4'h3;
            4'h0: tap_next = m ? 4'h5 : 4'h2;
            4'h5: tap_next = m ? 4'h7 : 4'hC;
            4'h4: tap_next = m ? 4'hF : 4'hE;
            4'hE: tap_next = m ? 4'h9 : 4'hA;
            4'hA: tap_next = m ? 4'h9 : 4'hA;
            4'h9: tap_next = m ? 4'hD : 4'hB;
            4'hB: tap_next = m ? 4'h8 : 4'hB;
            4'h8: tap_next = m ? 4'hD : 4'hA;
            4'hD: tap_next = m ? 4'h7 : 4'hC;
            default: tap_next = 4'hF;
        endcase
    endfunction

    // ERR is the one-cycle error response; it accepts commands like IDLE.
    assign bus.cmd_ready = (state == IDLE) || (state == ERR);
    assign busy          = !bus.cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cap_ph_n  = cap_ph;
        ir_n      = ir_q;
        rst_cmd_n = rst_cmd;
        done_n    = 1'b0;
        err_n     = 1'b0;
        accept    = 1'b0;
        shift_en  = 1'b0;
        load_rsp  = 1'b0;
        case (state)
            IDLE, ERR: begin
                state_n = IDLE;
                if (bus.cmd_valid) begin
                    accept = 1'b1;
                    if (bus.cmd_op == OP_RESET) begin
                        state_n   = RST_SEQ;
                        cnt_n     = '0;
                        rst_cmd_n = 1'b1;
                    end else if (bus.cmd_len == '0 ||
                                 (bus.cmd_op != OP_IDLE && bus.cmd_len > MAXL)) begin
                        state_n = ERR;
                        done_n  = 1'b1;
                        err_n   = 1'b1;
                    end else begin
                        state_n = (bus.cmd_op == OP_IDLE) ? IDLE_CNT : SEL_DR;
                        cnt_n   = bus.cmd_len - ONE;
                        ir_n    = (bus.cmd_op == OP_IR);
                    end
                end
            end
            RST_SEQ: begin
                if (cnt == RST_LAST) begin
                    state_n   = IDLE;
                    done_n    = rst_cmd;
                    rst_cmd_n = 1'b0;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            SEL_DR: begin
                state_n  = ir_q ? SEL_IR : CAPTURE;
                cap_ph_n = 1'b0;
            end
            SEL_IR: begin
                state_n  = CAPTURE;
                cap_ph_n = 1'b0;
            end
            // Two zeros: Select->Capture, then Capture->Shift.
            CAPTURE: begin
                if (cap_ph) state_n = SHIFT;
                else        cap_ph_n = 1'b1;
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt == '0) state_n = EXIT1;
                else           cnt_n   = cnt - ONE;
            end
            EXIT1:  state_n = UPDATE;
            UPDATE: begin
                state_n  = IDLE;
                done_n   = 1'b1;
                load_rsp = 1'b1;
            end
            IDLE_CNT: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            default: state_n = RST_SEQ;
        endcase

        // TMS/TDI are registered, so they are decoded from the state being entered.
        tms_n = 1'b0;
        tdi_n = 1'b0;
        case (state_n)
            RST_SEQ:               tms_n = (cnt_n != RST_LAST);
            SEL_DR, SEL_IR, EXIT1: tms_n = 1'b1;
            SHIFT: begin
                tms_n = (cnt_n == '0);
                tdi_n = (state == SHIFT) ? data_sh[1] : data_sh[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            state       <= RST_SEQ;
            cnt         <= '0;
            cap_ph      <= 1'b0;
            ir_q        <= 1'b0;
            rst_cmd     <= 1'b0;
            tms         <= 1'b1;
            tdi         <= 1'b0;
            tap_state   <= 4'hF;
            len_q       <= '0;
            data_sh     <= '0;
            cap         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cap_ph      <= cap_ph_n;
            ir_q        <= ir_n;
            rst_cmd     <= rst_cmd_n;
            tms         <= tms_n;
            tdi         <= tdi_n;
            tap_state   <= tap_next(tap_state, tms);
            rsp_valid_q <= done_n;
            rsp_err_q   <= err_n;
            if (accept) begin
                len_q   <= bus.cmd_len;
                data_sh <= bus.cmd_data;
                cap     <= '0;
            end
            if (shift_en) begin
                data_sh <= data_sh >> 1;
                cap     <= {tdo, cap[MAXLEN-1:1]};
            end
            // Captured bits enter at the MSB; right-align them to bit 0.
            if (load_rsp) rsp_data_q <= cap >> (MAXL - len_q);
        end
    end
endmodule
